// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage: PC register, IF/ID capture, freeze and branch flush (optional FETCH_PERF_CNT_EN counters)
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] inst_mem_addr,
  input  logic [31:0] inst_mem_data,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        valid_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic        advance;
  logic        unused_addr_bits;

  // Branch targets are word-aligned by dropping the two low address bits.
  assign branch_target    = {branch_addr[31:2], 2'b00};
  assign unused_addr_bits = ^branch_addr[1:0];
  assign pc_plus4         = pc + 32'd4;
  assign advance          = !branch_taken && !freeze;
  assign inst_mem_addr    = pc;

  // Program counter: branch wins over freeze, otherwise step by one word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (branch_taken) begin
      pc <= branch_target;
    end else if (!freeze) begin
      pc <= pc_plus4;
    end
  end

  // IF/ID register: flush to NOP on branch, hold on freeze, else capture fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_out    <= 32'd0;
      inst_out  <= NOP_INST;
      valid_out <= 1'b0;
    end else if (branch_taken) begin
      pc_out    <= 32'd0;
      inst_out  <= NOP_INST;
      valid_out <= 1'b0;
    end else if (!freeze) begin
      pc_out    <= pc_plus4;
      inst_out  <= inst_mem_data;
      valid_out <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Performance counters: real fetches and stall cycles; flush edges count neither.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (advance) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (freeze && !branch_taken) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with behavioural model and random stimulus
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'd0;
  logic [31:0] inst_mem_addr;
  logic [31:0] inst_mem_data;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        valid_out;
  logic [31:0] scr = 32'd0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // model of architectural state
  logic [31:0] m_pc, m_pcout, m_inst;
  logic        m_valid;
  logic [31:0] m_fc, m_sc;

  // instruction memory: word at address a is a ^ scr
  assign inst_mem_data = inst_mem_addr ^ scr;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk),
    .rst(rst),
    .freeze(freeze),
    .branch_taken(branch_taken),
    .branch_addr(branch_addr),
    .inst_mem_addr(inst_mem_addr),
    .inst_mem_data(inst_mem_data),
    .pc_out(pc_out),
    .inst_out(inst_out),
    .valid_out(valid_out)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count(fetch_count),
    .stall_count(stall_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC;
    m_pcout = 32'd0;
    m_inst = NOP_INST;
    m_valid = 1'b0;
    m_fc = 32'd0;
    m_sc = 32'd0;
  endtask

  // behavioural model: one rule applied per clock edge
  always @(posedge clk) begin
    if (rst) begin
      if (branch_taken) begin
        m_pc = branch_addr & ~32'd3;
        m_pcout = 32'd0;
        m_inst = NOP_INST;
        m_valid = 1'b0;
      end else if (freeze) begin
        m_sc = m_sc + 1;
      end else begin
        m_inst = m_pc ^ scr;
        m_pc = m_pc + 4;
        m_pcout = m_pc;
        m_valid = 1'b1;
        m_fc = m_fc + 1;
      end
    end
  end

  // compare process: checks every cycle while out of reset
  always @(negedge clk) begin
    if (rst && chk_en) begin
      chk("inst_mem_addr", inst_mem_addr, m_pc);
      chk("pc_out", pc_out, m_pcout);
      chk("inst_out", inst_out, m_inst);
      chk("valid_out", {31'd0, valid_out}, {31'd0, m_valid});
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_count", fetch_count, m_fc);
      chk("stall_count", stall_count, m_sc);
`endif
    end
  end

  task automatic step(input logic f, input logic b, input logic [31:0] a);
    freeze = f;
    branch_taken = b;
    branch_addr = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset inst_mem_addr", inst_mem_addr, 32'h0);
    chk("reset inst_out", inst_out, NOP_INST);
    chk("reset valid_out", {31'd0, valid_out}, 32'd0);
    chk("reset pc_out", pc_out, 32'h0);
    rst = 1'b1;
    chk_en = 1'b1;

    // sequential fetch, memory word = address
    repeat (3) step(1'b0, 1'b0, 32'd0);
    chk("seq inst_mem_addr", inst_mem_addr, 32'd12);
    chk("seq pc_out", pc_out, 32'd12);
    chk("seq inst_out", inst_out, 32'd8);
    chk("seq valid_out", {31'd0, valid_out}, 32'd1);

    // freeze two cycles at pc=12
    repeat (2) begin
      step(1'b1, 1'b0, 32'd0);
      chk("frz pc", inst_mem_addr, 32'd12);
      chk("frz inst_out", inst_out, 32'd8);
    end
    step(1'b0, 1'b0, 32'd0);
    chk("unfrz inst_out", inst_out, 32'd12);
    chk("unfrz pc", inst_mem_addr, 32'd16);

    // branch with simultaneous freeze at pc=16
    step(1'b1, 1'b1, 32'h0000_0103);
    chk("br pc", inst_mem_addr, 32'h100);
    chk("br valid_out", {31'd0, valid_out}, 32'd0);
    chk("br inst_out", inst_out, NOP_INST);
    chk("br pc_out", pc_out, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    chk("br tgt inst_out", inst_out, 32'h100);
    chk("br tgt pc_out", pc_out, 32'h104);

    // wrap at top of address space
    step(1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("wrap br pc", inst_mem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'd0);
    chk("wrap pc", inst_mem_addr, 32'h0);
    chk("wrap pc_out", pc_out, 32'h0);
    chk("wrap inst_out", inst_out, 32'hFFFF_FFFC);

    // randomized phase with scrambled memory contents
    scr = 32'h5A5A_C3C3;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 1, $urandom);
    end

    // asynchronous reset between edges
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    chk("async rst pc", inst_mem_addr, RESET_PC);
    chk("async rst inst_out", inst_out, NOP_INST);
    chk("async rst valid_out", {31'd0, valid_out}, 32'd0);
    chk("async rst pc_out", pc_out, 32'd0);
    @(posedge clk);
    #1;
    chk("rst hold pc", inst_mem_addr, RESET_PC);
    rst = 1'b1;

    // counter scenario: 10 fetches, 3 stalls, 1 flush
    repeat (10) step(1'b0, 1'b0, 32'd0);
    repeat (3) step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'h40);
    chk("cnt pc", inst_mem_addr, 32'h40);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count literal", fetch_count, 32'd10);
    chk("stall_count literal", stall_count, 32'd3);
`endif
    step(1'b0, 1'b0, 32'd0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage ARM pipeline. Owns the program counter, drives the word address into the combinational instruction memory, and captures the returned instruction plus PC+4 into the IF/ID pipeline register. Handles hazard freeze from the ID-stage hazard unit and branch redirect/flush from EX.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word inserted into IF/ID on flush/reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-low.
- freeze  input  1  hazard stall; hold PC and IF/ID contents.
- branch_taken  input  1  redirect fetch to branch_addr and flush IF/ID.
- branch_addr  input  32  branch target byte address.
- inst_mem_addr  output  32  byte address to instruction memory (= PC register).
- inst_mem_data  input  32  instruction word returned combinationally by instruction memory.
- pc_out  output  32  IF/ID: fetched address + 4.
- inst_out  output  32  IF/ID: fetched instruction.
- valid_out  output  1  IF/ID: 1 when inst_out is a real fetched instruction, 0 for inserted NOP.

## Operation
- PC register `pc`; inst_mem_addr = pc (combinational, no extra logic).
- Per rising edge, priority highest first:
  - branch_taken: pc <= {branch_addr[31:2], 2'b00}; IF/ID <= {pc_out=0, inst_out=NOP_INST, valid_out=0}.
  - freeze: pc, pc_out, inst_out, valid_out all hold.
  - otherwise: pc <= pc + 4; pc_out <= pc + 4; inst_out <= inst_mem_data; valid_out <= 1.
- branch_taken overrides freeze when both asserted in the same cycle.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- branch_addr[1:0] is ignored (forced to zero); no misalignment error.

## Timing
- Reset (rst=0, asynchronous, independent of clk): pc=RESET_PC, pc_out=0, inst_out=NOP_INST, valid_out=0; counters (if enabled) = 0.
- First fetch: first rising edge after rst deasserts captures instruction at RESET_PC; valid_out=1 in that cycle.
- Fetch latency: instruction at address A appears on inst_out exactly one edge after pc=A.
- Branch penalty: branch_taken in cycle n -> pc=target after edge n, IF/ID holds NOP (valid_out=0) during cycle n+1, target instruction in IF/ID after edge n+1.
- Freeze is level-sensitive; each frozen cycle adds one cycle of hold, no lost or duplicated instruction.
- Reset asserted mid-operation discards in-flight state immediately; no partial update on the following edge.
- Throughput: one instruction per cycle when freeze=0 and branch_taken=0.

## Configuration
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs fetch_count[31:0] (increments on each edge that loads a valid instruction into IF/ID) and stall_count[31:0] (increments on each edge with freeze=1 and branch_taken=0). Both reset to 0, wrap modulo 2^32, not incremented on flush edges.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset: hold rst=0 for 3 cycles with RESET_PC=0 -> inst_mem_addr=0, inst_out=NOP_INST, valid_out=0, pc_out=0; release -> after 3 edges inst_mem_addr=12, pc_out=12, valid_out=1.
- Sequential fetch: memory returns word = address -> inst_out sequence 0,4,8,... one edge behind inst_mem_addr, pc_out = inst_out + 4.
- Freeze: assert freeze 2 cycles at pc=8 -> pc stays 8, inst_out stays 4 for both cycles; release -> inst_out=8, no skip or repeat.
- Branch with simultaneous freeze: at pc=16 assert branch_taken=1, freeze=1, branch_addr=32'h0000_0103 -> next pc=0x100, valid_out=0, inst_out=NOP_INST; following edge inst_out=word@0x100, pc_out=0x104.
- Wrap and mid-op reset: branch to 32'hFFFF_FFFC -> next fetch address 0; assert rst asynchronously between edges -> outputs reset immediately, pc=RESET_PC.
- With FETCH_PERF_CNT_EN: 10 free-running fetches, 3 freeze cycles, 1 branch -> fetch_count=10, stall_count=3, flush cycle increments neither.
